// File: rtl/hnf_link_tx_if.sv
// Link-side bundle for hnf_link_tx: FIFO read port, credited flit channel and link status.
// The master modport is the transmitter; the slave modport is the FIFO/receiver side.
interface hnf_link_tx_if #(
   parameter int FLIT_WIDTH = 32,
   parameter int MAX_CRD    = 15
);
   localparam int CRD_W = $clog2(MAX_CRD + 1);

   logic                  fifo_empty;
   logic [FLIT_WIDTH-1:0] fifo_rd_data;
   logic                  fifo_rd_en;
   logic                  link_en;
   logic                  rxlinkactiveack;
   logic                  rxlcrdv;
   logic                  txlinkactivereq;
   logic                  txflitpend;
   logic                  txflitv;
   logic [FLIT_WIDTH-1:0] txflit;
   logic                  txflit_lcrd;
   logic [CRD_W-1:0]      crd_cnt;
   logic                  crd_err;
   logic [1:0]            link_state;

   modport master (
      input  fifo_empty, fifo_rd_data, link_en, rxlinkactiveack, rxlcrdv,
      output fifo_rd_en, txlinkactivereq, txflitpend, txflitv, txflit, txflit_lcrd,
             crd_cnt, crd_err, link_state
   );

   modport slave (
      output fifo_empty, fifo_rd_data, link_en, rxlinkactiveack, rxlcrdv,
      input  fifo_rd_en, txlinkactivereq, txflitpend, txflitv, txflit, txflit_lcrd,
             crd_cnt, crd_err, link_state
   );
endinterface

// File: rtl/hnf_link_tx.sv
// CHI-style link-layer transmitter: drains an egress flit FIFO onto a credited link,
// runs the STOP/ACTIVATE/RUN/DEACTIVATE handshake and returns unused L-credits on teardown.
module hnf_link_tx #(
   parameter int FLIT_WIDTH = 32,
   parameter int MAX_CRD    = 15
) (
   input  logic          clk,
   input  logic          rst,
   hnf_link_tx_if.master lnk
);
   localparam int CRD_W = $clog2(MAX_CRD + 1);
   localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(MAX_CRD);

   typedef enum logic [1:0] {
      ST_STOP       = 2'd0,
      ST_ACTIVATE   = 2'd1,
      ST_RUN        = 2'd2,
      ST_DEACTIVATE = 2'd3
   } state_t;

   state_t                state;
   state_t                state_nx;
   logic [CRD_W-1:0]      crd_cnt_p1;
   logic                  crd_err_p1;
   logic                  req_p1;
   logic                  pend_p1;
   logic                  flitv_p1;
   logic                  lcrd_p1;
   logic [FLIT_WIDTH-1:0] flit_p1;

   logic                  send_p0;
   logic                  ret_p0;
   logic                  inc_p0;
   logic                  dec_p0;
   logic [CRD_W:0]        crd_upd_p0;

   // Saturating credit update; the extra MSB flags an increment lost at the ceiling.
   function automatic logic [CRD_W:0] crd_update(input logic [CRD_W-1:0] cnt,
                                                 input logic inc, input logic dec);
      logic [CRD_W:0] r;
      r = {1'b0, cnt};
      if (inc && !dec) begin
         if (cnt == CRD_MAX) r = {1'b1, cnt};
         else                r = {1'b0, cnt + 1'b1};
      end else if (dec && !inc) begin
         r = {1'b0, cnt - 1'b1};
      end
      return r;
   endfunction

   always_comb begin
      state_nx = state;
      case (state)
         ST_STOP:       if (lnk.link_en && !lnk.rxlinkactiveack) state_nx = ST_ACTIVATE;
         ST_ACTIVATE:   if (lnk.rxlinkactiveack) state_nx = ST_RUN;
         ST_RUN:        if (!lnk.link_en) state_nx = ST_DEACTIVATE;
         ST_DEACTIVATE: if (!lnk.rxlinkactiveack && (crd_cnt_p1 == '0) && !lnk.rxlcrdv)
                           state_nx = ST_STOP;
         default:       state_nx = ST_STOP;
      endcase
   end

   // Stage p0: decide send/return from registered state and credits only, so a
   // credit arriving this cycle is never spent in the same cycle.
   assign send_p0    = (state == ST_RUN) && !lnk.fifo_empty && (crd_cnt_p1 != '0);
   assign ret_p0     = (state == ST_DEACTIVATE) && (crd_cnt_p1 != '0);
   assign inc_p0     = lnk.rxlcrdv && (state != ST_STOP);
   assign dec_p0     = send_p0 || ret_p0;
   assign crd_upd_p0 = crd_update(crd_cnt_p1, inc_p0, dec_p0);

   // Stage p1: registered link outputs and credit state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_STOP;
         crd_cnt_p1 <= '0;
         crd_err_p1 <= 1'b0;
         req_p1     <= 1'b0;
         pend_p1    <= 1'b0;
         flitv_p1   <= 1'b0;
         lcrd_p1    <= 1'b0;
         flit_p1    <= '0;
      end else begin
         state      <= state_nx;
         crd_cnt_p1 <= crd_upd_p0[CRD_W-1:0];
         crd_err_p1 <= crd_err_p1 || crd_upd_p0[CRD_W];
         req_p1     <= (state_nx == ST_ACTIVATE) || (state_nx == ST_RUN);
         pend_p1    <= (state_nx == ST_RUN) || (state_nx == ST_DEACTIVATE);
         flitv_p1   <= dec_p0;
         lcrd_p1    <= ret_p0;
         flit_p1    <= send_p0 ? lnk.fifo_rd_data : '0;
      end
   end

   assign lnk.fifo_rd_en      = send_p0;
   assign lnk.txlinkactivereq = req_p1;
   assign lnk.txflitpend      = pend_p1;
   assign lnk.txflitv         = flitv_p1;
   assign lnk.txflit          = flit_p1;
   assign lnk.txflit_lcrd     = lcrd_p1;
   assign lnk.crd_cnt         = crd_cnt_p1;
   assign lnk.crd_err         = crd_err_p1;
   assign lnk.link_state      = state;
endmodule
